// File: rtl/slug_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : slug_uart_bridge                                           |
// | Description : CPU-port to UART bridge. The CPU hands over TX bytes and   |
// |               takes RX bytes with toggle handshakes across a 32-bit      |
// |               output/input port pair. The RX path has a small FIFO and   |
// |               sticky overrun / framing-error flags.                      |
// | Ports       : clk      - sole clock                                      |
// |               rst      - synchronous active-high reset                   |
// |               cpu_out  - [7:0] tx byte, [8] tx_req toggle,               |
// |                          [12] rx_ack toggle, [13] err_clr level          |
// |               cpu_in   - [7:0] rx byte, [8] rx_tog, [9] tx_ack,          |
// |                          [10] tx_busy, [11] rx_overrun, [12] frame_err   |
// |               rxd      - asynchronous serial input, idle high            |
// |               txd      - serial output, idle high                        |
// | Options     : define SLUG_UART_BRIDGE_PARITY_EN to add an even-parity    |
// |               bit after the data bits, in both directions                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module slug_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_out,
    output logic [31:0] cpu_in,
    input  logic        rxd,
    output logic        txd
);

    localparam int            c_AW        = $clog2(RX_DEPTH);
    localparam logic [11:0]   c_BIT_LAST  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0]   c_HALF_LAST = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_AW:0] c_FULL      = RX_DEPTH[c_AW:0];

`ifdef SLUG_UART_BRIDGE_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Synchronizers; r_rxd_d is one extra stage used only for edge detection
    logic r_txreq_s1, r_txreq_s2;
    logic r_rxack_s1, r_rxack_s2;
    logic r_errclr_s1, r_errclr_s2;
    logic r_rxd_s1, r_rxd_s2, r_rxd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_txreq_s1, r_txreq_s2}   <= 2'b00;
            {r_rxack_s1, r_rxack_s2}   <= 2'b00;
            {r_errclr_s1, r_errclr_s2} <= 2'b00;
            {r_rxd_s1, r_rxd_s2}       <= 2'b00;
            r_rxd_d                    <= 1'b0;
        end else begin
            r_txreq_s1  <= cpu_out[8];
            r_txreq_s2  <= r_txreq_s1;
            r_rxack_s1  <= cpu_out[12];
            r_rxack_s2  <= r_rxack_s1;
            r_errclr_s1 <= cpu_out[13];
            r_errclr_s2 <= r_errclr_s1;
            r_rxd_s1    <= rxd;
            r_rxd_s2    <= r_rxd_s1;
            r_rxd_d     <= r_rxd_s2;
        end
    end

    // ------------------------------------------------------------------ TX
    state_t      r_tx_state;
    logic [11:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx_ack;
    logic        r_tx_busy;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
    logic        r_tx_par;
`endif

    // txd is registered and set together with the state it belongs to, so
    // every non-IDLE state drives its level for exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_ack   <= 1'b0;
            r_tx_busy  <= 1'b0;
            txd        <= 1'b1;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    txd      <= 1'b1;
                    r_tx_cnt <= '0;
                    // A toggle that arrived while busy is still unequal here
                    if (r_txreq_s2 != r_tx_ack) begin
                        r_tx_shift <= cpu_out[7:0];
`ifdef SLUG_UART_BRIDGE_PARITY_EN
                        r_tx_par   <= ^cpu_out[7:0];
`endif
                        r_tx_ack   <= r_txreq_s2;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= S_START;
                        txd        <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= S_DATA;
                        txd        <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 12'd1;
                    end
                end
                S_DATA: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
`ifdef SLUG_UART_BRIDGE_PARITY_EN
                            r_tx_state <= S_PARITY;
                            txd        <= r_tx_par;
`else
                            r_tx_state <= S_STOP;
                            txd        <= 1'b1;
`endif
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            txd        <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 12'd1;
                    end
                end
`ifdef SLUG_UART_BRIDGE_PARITY_EN
                S_PARITY: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= S_STOP;
                        txd        <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 12'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_busy  <= 1'b0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 12'd1;
                    end
                end
                default: begin
                    r_tx_state <= S_IDLE;
                    txd        <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    state_t      r_rx_state;
    logic [11:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        w_par_ok;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
    logic        r_rx_par_err;
    assign w_par_ok = ~r_rx_par_err;
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= S_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
            r_rx_par_err <= 1'b0;
`endif
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rxd_d && !r_rxd_s2) begin
                        r_rx_state <= S_START;
                    end
                end
                S_START: begin
                    // Half-bit check; from here on every sample is mid-bit
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rxd_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 12'd1;
                    end
                end
                S_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
`ifdef SLUG_UART_BRIDGE_PARITY_EN
                            r_rx_state <= S_PARITY;
`else
                            r_rx_state <= S_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'd1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 12'd1;
                    end
                end
`ifdef SLUG_UART_BRIDGE_PARITY_EN
                S_PARITY: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_err <= r_rxd_s2 ^ (^r_rx_shift);
                        r_rx_state   <= S_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 12'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 12'd1;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------- RX FIFO / CPU
    logic [7:0]      r_mem [RX_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_presented;
    logic [7:0]      r_rx_data;
    logic            r_rx_tog;
    logic            r_overrun;
    logic            r_frame_err;

    logic w_stop_sample, w_frame_ok, w_frame_bad, w_full, w_push, w_drop, w_pop;

    assign w_stop_sample = (r_rx_state == S_STOP) && (r_rx_cnt == c_BIT_LAST);
    assign w_frame_ok    = w_stop_sample && r_rxd_s2 && w_par_ok;
    assign w_frame_bad   = w_stop_sample && !(r_rxd_s2 && w_par_ok);
    assign w_full        = (r_count == c_FULL);
    assign w_push        = w_frame_ok && !w_full;
    assign w_drop        = w_frame_ok && w_full;
    // The head stays in the FIFO while presented; the CPU echoing rx_tog
    // on rx_ack is what releases it.
    assign w_pop         = r_presented && (r_rxack_s2 == r_rx_tog);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_presented <= 1'b0;
            r_rx_data   <= '0;
            r_rx_tog    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_presented <= 1'b0;
            end else if (!r_presented && r_count != '0) begin
                r_rx_data   <= r_mem[r_rd_ptr];
                r_rx_tog    <= ~r_rx_tog;
                r_presented <= 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // Set has priority over a concurrent clear
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (r_errclr_s2) begin
                r_overrun <= 1'b0;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (r_errclr_s2) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign cpu_in = {19'd0, r_frame_err, r_overrun, r_tx_busy, r_tx_ack, r_rx_tog, r_rx_data};

    logic w_unused_cpu_out;
    assign w_unused_cpu_out = ^{cpu_out[31:14], cpu_out[11:9]};

endmodule
`default_nettype wire

// File: tb/tb_slug_uart_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_slug_uart_bridge                                        |
// | Description : Self-checking bench for slug_uart_bridge. A queue-based    |
// |               model of the RX FIFO and CPU handshake plus a bit-list     |
// |               model of the serial frame supply every expected value.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_slug_uart_bridge;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_out;
    logic [31:0] cpu_in;
    logic        rxd;
    logic        txd;

    slug_uart_bridge #(.CLKS_PER_BIT(CPB), .RX_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu_out (cpu_out),
        .cpu_in  (cpu_in),
        .rxd     (rxd),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // CPU-side levels and reference model state
    logic       req_lvl, ack_lvl, clr_lvl;
    logic [7:0] tx_byte;
    logic [7:0] q[$];
    logic [7:0] exp_data;
    logic       exp_tog, exp_ovr, exp_fe, presented;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ignored cpu_out bits carry random junk
    task automatic drive_cpu();
        logic [31:0] junk;
        junk    = $urandom();
        cpu_out = {junk[31:14], clr_lvl, ack_lvl, junk[11:9], req_lvl, tx_byte};
    endtask

    // Bit 0 goes on the line first
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef SLUG_UART_BRIDGE_PARITY_EN
        f[9]   = ^b;
        f[10]  = stop;
`else
        f[9]   = stop;
`endif
        return f;
    endfunction

    function automatic void model_reset();
        q.delete();
        exp_data  = 8'h00;
        exp_tog   = 1'b0;
        exp_ovr   = 1'b0;
        exp_fe    = 1'b0;
        presented = 1'b0;
    endfunction

    function automatic void model_present();
        if (!presented && q.size() > 0) begin
            exp_data  = q[0];
            exp_tog   = ~exp_tog;
            presented = 1'b1;
        end
    endfunction

    task automatic chk_rx(input string tag);
        chk({tag, "_data"}, 32'(cpu_in[7:0]), 32'(exp_data));
        chk({tag, "_tog"},  32'(cpu_in[8]),   32'(exp_tog));
        chk({tag, "_ovr"},  32'(cpu_in[11]),  32'(exp_ovr));
        chk({tag, "_fe"},   32'(cpu_in[12]),  32'(exp_fe));
    endtask

    // Follows one TX frame from busy rising to busy falling
    task automatic watch_tx(input logic [7:0] b, input bit pend, input logic [7:0] nb);
        logic [10:0] fr;
        int          k;
        int          w;
        fr = frame_bits(b, 1'b1);
        w  = 0;
        while (cpu_in[10] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("tx_busy_rise", 32'(cpu_in[10]), 32'd1);
        chk("tx_ack", 32'(cpu_in[9]), 32'(req_lvl));
        k = 0;
        while (cpu_in[10] === 1'b1 && k < NB * CPB + 20) begin
            if (k % CPB == CPB / 2 && k / CPB < NB)
                chk($sformatf("txd_bit%0d", k / CPB), 32'(txd), 32'(fr[k / CPB]));
            if (pend && k == 50) begin
                tx_byte = nb;
                req_lvl = ~req_lvl;
                drive_cpu();
            end
            @(negedge clk);
            k++;
        end
        chk("tx_busy_len", 32'(k), 32'(NB * CPB));
        chk("txd_idle", 32'(txd), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic bad_stop);
        logic [10:0] fr;
        fr = frame_bits(b, ~bad_stop);
        for (int i = 0; i < NB; i++) begin
            rxd = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        if (bad_stop) begin
            exp_fe = 1'b1;
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            exp_ovr = 1'b1;
        end
        model_present();
    endtask

    task automatic ack_rx(input string tag);
        chk({tag, "_pre"}, 32'(cpu_in[7:0]), 32'(q[0]));
        ack_lvl = exp_tog;
        drive_cpu();
        repeat (6) @(negedge clk);
        void'(q.pop_front());
        presented = 1'b0;
        model_present();
        chk_rx(tag);
    endtask

    task automatic clear_err();
        clr_lvl = 1'b1;
        drive_cpu();
        repeat (3) @(negedge clk);
        clr_lvl = 1'b0;
        drive_cpu();
        repeat (4) @(negedge clk);
        exp_ovr = 1'b0;
        exp_fe  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nb;
        rst     = 1'b1;
        rxd     = 1'b1;
        req_lvl = 1'b0;
        ack_lvl = 1'b0;
        clr_lvl = 1'b0;
        tx_byte = 8'h00;
        drive_cpu();
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_cpu_in", cpu_in, 32'h0);
        chk("rst_txd", 32'(txd), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_cpu_in", cpu_in, 32'h0);

        // Directed TX of 0x55
        tx_byte = 8'h55;
        req_lvl = 1'b1;
        drive_cpu();
        watch_tx(8'h55, 1'b0, 8'h00);

        // Random TX bytes; the middle one queues a second request while busy
        for (int i = 0; i < 3; i++) begin
            tx_byte = 8'($urandom());
            req_lvl = ~req_lvl;
            drive_cpu();
            nb = 8'($urandom());
            watch_tx(tx_byte, i == 1, nb);
            if (i == 1) watch_tx(nb, 1'b0, 8'h00);
        end
        repeat (20) @(negedge clk);
        chk("tx_no_dup", 32'(cpu_in[10]), 32'd0);

        // Directed RX of 0xA3 and its acknowledge
        send_rx(8'hA3, 1'b0);
        chk_rx("rx_a3");
        ack_rx("rx_a3_ack");

        // Bad stop bit, then clear
        send_rx(8'($urandom()), 1'b1);
        chk_rx("rx_badstop");
        clear_err();
        chk_rx("rx_errclr");

        // Short low pulse on rxd
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk_rx("rx_glitch");

        // Overflow: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b0);
        chk_rx("rx_ovf");
        for (int i = 0; i < 4; i++) ack_rx($sformatf("rx_ovf_ack%0d", i));
        repeat (10) @(negedge clk);
        chk_rx("rx_ovf_empty");
        clear_err();
        chk_rx("rx_ovf_clr");

        // Random RX traffic interleaved with acknowledges
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 2) == 0 && q.size() > 0) begin
                ack_rx($sformatf("rnd_ack%0d", i));
            end else begin
                send_rx(8'($urandom()), $urandom_range(0, 5) == 0);
                chk_rx($sformatf("rnd_rx%0d", i));
            end
        end

        // Reset in the middle of a TX frame (0xA4 has data bit 1 = 0)
        tx_byte = 8'hA4;
        req_lvl = ~req_lvl;
        drive_cpu();
        begin
            int w;
            w = 0;
            while (cpu_in[10] !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        chk("mid_busy", 32'(cpu_in[10]), 32'd1);
        repeat (40) @(negedge clk);
        rst     = 1'b1;
        req_lvl = 1'b0;
        ack_lvl = 1'b0;
        clr_lvl = 1'b0;
        drive_cpu();
        @(negedge clk);
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_cpu_in", cpu_in, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("post_rst_cpu_in", cpu_in, 32'h0);
        tx_byte = 8'($urandom());
        req_lvl = 1'b1;
        drive_cpu();
        watch_tx(tx_byte, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
